// File: rtl/tanimoto_stim_gen.sv
// On-chip stimulus source: loads the Tanimoto threshold BRAM, then streams a ROM vector image
// over AXI-Stream. The threshold load phase is built only when TANIMOTO_STIM_THR_LOAD_EN is defined.
//
// state    | meaning
// IDLE     | waiting for start
// THR_LOAD | writing one threshold entry per cycle
// STREAM   | reading ROM words and offering beats
// DONE     | one-cycle completion pulse
module tanimoto_stim_gen #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int VEC_NO       = 32,
  parameter int THR_NUM      = 134,
  parameter int THR_DEN      = 34,
  parameter int THR_WIDTH    = 12,
  parameter int ADDR_WIDTH   = $clog2(VECTOR_WIDTH+1),
  localparam int NUM_BEATS   = (VEC_NO*VECTOR_WIDTH+BUS_WIDTH-1)/BUS_WIDTH,
  localparam int BEAT_AW     = $clog2(NUM_BEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            gap,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] thr_addr,
  output logic [THR_WIDTH-1:0]  thr_wrdata,
  output logic                  thr_we,
  output logic [BEAT_AW-1:0]    rom_addr,
  output logic                  rom_en,
  input  logic [BUS_WIDTH-1:0]  rom_data,
  output logic [BUS_WIDTH-1:0]  M_AXIS_DATA_tdata,
  output logic                  M_AXIS_DATA_tvalid,
  output logic                  M_AXIS_DATA_tlast,
  input  logic                  M_AXIS_DATA_tready
);

  typedef enum logic [1:0] {IDLE, THR_LOAD, STREAM, DONE} state_t;

  localparam logic [BEAT_AW-1:0] LAST_BEAT = BEAT_AW'(NUM_BEATS-1);

  state_t               state, state_nxt;
  logic [3:0]           gap_r, gap_cnt;
  logic [BEAT_AW-1:0]   rom_addr_r, out_cnt;
  logic                 issue_done, rd_pend;
  logic [BUS_WIDTH-1:0] buf_mem [2];
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           occ, fill;
  logic                 tvalid, hs, last_hs, rd_go, thr_last;

  assign tvalid  = (state == STREAM) && (occ != 2'd0) && (gap_cnt == 4'd0);
  assign hs      = tvalid && M_AXIS_DATA_tready;
  assign last_hs = hs && (out_cnt == LAST_BEAT);
  // occupancy after this cycle's pop plus the read already on its way back
  assign fill    = occ + {1'b0, rd_pend} - {1'b0, hs};
  assign rd_go   = (state == STREAM) && !issue_done && (fill < 2'd2);

  assign busy               = (state != IDLE);
  assign done               = (state == DONE);
  assign rom_en             = rd_go;
  assign rom_addr           = rom_addr_r;
  assign M_AXIS_DATA_tvalid = tvalid;
  assign M_AXIS_DATA_tdata  = buf_mem[rd_ptr];
  assign M_AXIS_DATA_tlast  = tvalid && (out_cnt == LAST_BEAT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef TANIMOTO_STIM_THR_LOAD_EN
          state_nxt = THR_LOAD;
`else
          state_nxt = STREAM;
`endif
        end
      end
      THR_LOAD: if (thr_last) state_nxt = STREAM;
      STREAM:   if (last_hs) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gap_r      <= '0;
      gap_cnt    <= '0;
      rom_addr_r <= '0;
      out_cnt    <= '0;
      issue_done <= 1'b0;
      rd_pend    <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      occ        <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) gap_r <= gap;
      if (state != STREAM) begin
        gap_cnt    <= '0;
        rom_addr_r <= '0;
        out_cnt    <= '0;
        issue_done <= 1'b0;
        rd_pend    <= 1'b0;
        rd_ptr     <= 1'b0;
        wr_ptr     <= 1'b0;
        occ        <= '0;
      end else begin
        rd_pend <= rd_go;
        if (rd_go) begin
          rom_addr_r <= rom_addr_r + BEAT_AW'(1);
          if (rom_addr_r == LAST_BEAT) issue_done <= 1'b1;
        end
        if (rd_pend) begin
          buf_mem[wr_ptr] <= rom_data;
          wr_ptr          <= ~wr_ptr;
        end
        if (hs) begin
          rd_ptr  <= ~rd_ptr;
          out_cnt <= out_cnt + BEAT_AW'(1);
          gap_cnt <= gap_r;
        end else if (gap_cnt != 4'd0) begin
          gap_cnt <= gap_cnt - 4'd1;
        end
        occ <= fill;
      end
    end
  end

`ifdef TANIMOTO_STIM_THR_LOAD_EN
  localparam int Q0 = THR_NUM / THR_DEN;
  localparam int R0 = THR_NUM % THR_DEN;
  localparam int QW = THR_WIDTH + $clog2(Q0+2) + 1;
  localparam int RW = $clog2(2*THR_DEN) + 1;

  logic [ADDR_WIDTH-1:0] thr_cnt;
  logic [QW-1:0]         q, q_nxt;
  logic [RW-1:0]         r, r_sum, r_nxt;
  logic                  sat;

  assign thr_last = (thr_cnt == ADDR_WIDTH'(VECTOR_WIDTH));

  // floor(c*NUM/DEN) stepped without a divider: r < DEN always, so one correction suffices
  always_comb begin
    r_sum = r + RW'(R0);
    r_nxt = r_sum;
    q_nxt = q + QW'(Q0);
    if (r_sum >= RW'(THR_DEN)) begin
      r_nxt = r_sum - RW'(THR_DEN);
      q_nxt = q + QW'(Q0) + QW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != THR_LOAD) begin
      thr_cnt <= '0;
      q       <= '0;
      r       <= '0;
      sat     <= 1'b0;
    end else begin
      thr_cnt <= thr_cnt + ADDR_WIDTH'(1);
      r       <= r_nxt;
      if (!sat) begin
        q   <= q_nxt;
        sat <= (q_nxt[QW-1:THR_WIDTH] != '0);
      end
    end
  end

  assign thr_we     = (state == THR_LOAD);
  assign thr_addr   = thr_we ? thr_cnt : '0;
  assign thr_wrdata = !thr_we ? '0 : (sat ? '1 : q[THR_WIDTH-1:0]);
`else
  assign thr_last   = 1'b1;
  assign thr_we     = 1'b0;
  assign thr_addr   = '0;
  assign thr_wrdata = '0;
`endif

endmodule

// File: tb/tb_tanimoto_stim_gen.sv
// Self-checking bench for tanimoto_stim_gen: random ROM image, random backpressure and gaps,
// checked against arithmetic expectations; threshold checks apply when TANIMOTO_STIM_THR_LOAD_EN is set.
`timescale 1ns/1ps
module tb_tanimoto_stim_gen;
  localparam int BW = 128, VW = 920, VN = 32, TN = 134, TD = 34, TW = 12;
  localparam int AW = $clog2(VW+1);
  localparam int NB = (VN*VW+BW-1)/BW;
  localparam int BAW = $clog2(NB);
  localparam int BUDGET = 6000;

  logic clk = 1'b0;
  logic rst, start, tready;
  logic [3:0] gap;
  logic busy, done, thr_we, rom_en, tvalid, tlast;
  logic [AW-1:0] thr_addr;
  logic [TW-1:0] thr_wrdata;
  logic [BAW-1:0] rom_addr;
  logic [BW-1:0] rom_data, tdata;
  logic busy11, done11, thr_we11, rom_en11, tvalid11, tlast11;
  logic [AW-1:0] thr_addr11;
  logic [10:0] thr_wrdata11;
  logic [BAW-1:0] rom_addr11;
  logic [BW-1:0] rom_data11, tdata11;

  logic [BW-1:0] image [NB];

  int passed = 0, total = 0;
  logic [BW-1:0] beats[$];
  logic lasts[$];
  int hs_i[$], thr_a[$], thr_d[$], thr_d11[$];
  int first_we, first_en, first_v, first_rom_addr, done_cnt, done_i;
  int stable_err, stray_last, diff11, tied_err, busy_after, timed_out;

  always #5 clk = ~clk;

  tanimoto_stim_gen #(.BUS_WIDTH(BW), .VECTOR_WIDTH(VW), .VEC_NO(VN), .THR_NUM(TN),
                      .THR_DEN(TD), .THR_WIDTH(TW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .gap(gap), .busy(busy), .done(done),
    .thr_addr(thr_addr), .thr_wrdata(thr_wrdata), .thr_we(thr_we),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .M_AXIS_DATA_tdata(tdata), .M_AXIS_DATA_tvalid(tvalid),
    .M_AXIS_DATA_tlast(tlast), .M_AXIS_DATA_tready(tready));

  tanimoto_stim_gen #(.BUS_WIDTH(BW), .VECTOR_WIDTH(VW), .VEC_NO(VN), .THR_NUM(TN),
                      .THR_DEN(TD), .THR_WIDTH(11)) u_dut11 (
    .clk(clk), .rst(rst), .start(start), .gap(gap), .busy(busy11), .done(done11),
    .thr_addr(thr_addr11), .thr_wrdata(thr_wrdata11), .thr_we(thr_we11),
    .rom_addr(rom_addr11), .rom_en(rom_en11), .rom_data(rom_data11),
    .M_AXIS_DATA_tdata(tdata11), .M_AXIS_DATA_tvalid(tvalid11),
    .M_AXIS_DATA_tlast(tlast11), .M_AXIS_DATA_tready(tready));

  // ROM with one cycle read latency
  always @(posedge clk) begin
    if (rom_en)   rom_data   <= (int'(rom_addr) < NB) ? image[rom_addr] : '0;
    if (rom_en11) rom_data11 <= (int'(rom_addr11) < NB) ? image[rom_addr11] : '0;
  end

  function automatic int thr_model(input int c, input int tw);
    int v, mx;
    v = (c * TN) / TD;
    mx = (1 << tw) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int stream_start();
`ifdef TANIMOTO_STIM_THR_LOAD_EN
    return VW + 2;
`else
    return 1;
`endif
  endfunction

  // start a run and record what the outputs do, cycle by cycle, relative to the start cycle
  task automatic do_run(input int gapv, input int duty, input int abort_beats);
    logic prev_stall = 1'b0;
    logic [BW-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    beats.delete(); lasts.delete(); hs_i.delete();
    thr_a.delete(); thr_d.delete(); thr_d11.delete();
    first_we = -1; first_en = -1; first_v = -1; first_rom_addr = -1;
    done_cnt = 0; done_i = -1; stable_err = 0; stray_last = 0; diff11 = 0;
    tied_err = 0; busy_after = -1; timed_out = 1;
    @(negedge clk);
    gap = 4'(gapv); start = 1'b1; tready = 1'b1;
    for (int i = 1; i < BUDGET; i++) begin
      @(negedge clk);
      start = 1'b0;
      gap = 4'($urandom_range(15));
      tready = ($urandom_range(99) < duty);
      #1;
`ifdef TANIMOTO_STIM_THR_LOAD_EN
      if (thr_we) begin
        thr_a.push_back(int'(thr_addr));
        thr_d.push_back(int'(thr_wrdata));
        if (first_we < 0) first_we = i;
      end
      if (thr_we11) thr_d11.push_back(int'(thr_wrdata11));
      if (thr_we11 !== thr_we || thr_addr11 !== thr_addr) diff11++;
`else
      if (thr_we || thr_we11 || thr_addr != 0 || thr_addr11 != 0 || thr_wrdata != 0 || thr_wrdata11 != 0)
        tied_err++;
`endif
      if (rom_en && first_en < 0) begin
        first_en = i;
        first_rom_addr = int'(rom_addr);
      end
      if ({tvalid11, tlast11, busy11, done11} !== {tvalid, tlast, busy, done} || tdata11 !== tdata)
        diff11++;
      if (prev_stall && (tvalid !== 1'b1 || tdata !== prev_d || tlast !== prev_l)) stable_err++;
      if (tlast && !tvalid) stray_last++;
      if (tvalid && first_v < 0) first_v = i;
      if (tvalid && tready) begin
        beats.push_back(tdata);
        lasts.push_back(tlast);
        hs_i.push_back(i);
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      prev_l = tlast;
      if (done) begin
        done_cnt++;
        if (done_i < 0) done_i = i;
      end
      if (done_i >= 0 && i == done_i + 1) begin
        busy_after = int'(busy);
        timed_out = 0;
        break;
      end
      if (abort_beats > 0 && beats.size() >= abort_beats) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  function automatic int beat_errors();
    int bad = 0;
    for (int k = 0; k < beats.size(); k++)
      if (k >= NB || beats[k] !== image[k]) bad++;
    return bad;
  endfunction

  function automatic int last_hs();
    return (hs_i.size() > 0) ? hs_i[hs_i.size()-1] : -100;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tready = 1'b0; gap = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    total++; if (thr_we !== 1'b0) $display("FAIL rst_thr_we: got %b want 0", thr_we); else passed++;
    total++; if (thr_addr !== '0) $display("FAIL rst_thr_addr: got %0d want 0", thr_addr); else passed++;
    total++; if (thr_wrdata !== '0) $display("FAIL rst_thr_wrdata: got %0d want 0", thr_wrdata); else passed++;
    total++; if (rom_en !== 1'b0) $display("FAIL rst_rom_en: got %b want 0", rom_en); else passed++;
    total++; if (rom_addr !== '0) $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); else passed++;
    total++; if (tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", tvalid); else passed++;
    total++; if (tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", tlast); else passed++;
    total++; if (tdata !== '0) $display("FAIL rst_tdata: got %h want 0", tdata); else passed++;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL start_with_rst_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_basic();
    int bad;
    do_run(0, 100, 0);
    total++; if (timed_out != 0) $display("FAIL basic_timeout: got %0d want 0", timed_out); else passed++;
    total++; if (beats.size() != NB) $display("FAIL basic_beats: got %0d want %0d", beats.size(), NB); else passed++;
    bad = beat_errors();
    total++; if (bad != 0) $display("FAIL basic_data: got %0d bad beats want 0", bad); else passed++;
    bad = 0;
    for (int k = 0; k < lasts.size(); k++) if (lasts[k] !== (k == NB-1)) bad++;
    total++; if (bad != 0) $display("FAIL basic_tlast: got %0d bad flags want 0", bad); else passed++;
    total++; if (first_en != stream_start()) $display("FAIL basic_first_rom_en: got %0d want %0d", first_en, stream_start()); else passed++;
    total++; if (first_rom_addr != 0) $display("FAIL basic_first_rom_addr: got %0d want 0", first_rom_addr); else passed++;
    total++; if (first_v != stream_start() + 2) $display("FAIL basic_first_tvalid: got %0d want %0d", first_v, stream_start() + 2); else passed++;
    total++; if (last_hs() - first_en + 1 != NB + 2) $display("FAIL basic_duration: got %0d want %0d", last_hs() - first_en + 1, NB + 2); else passed++;
    total++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt); else passed++;
    total++; if (done_i != last_hs() + 1) $display("FAIL basic_done_cycle: got %0d want %0d", done_i, last_hs() + 1); else passed++;
    total++; if (busy_after != 0) $display("FAIL basic_busy_after: got %0d want 0", busy_after); else passed++;
    total++; if (diff11 != 0) $display("FAIL basic_width_independent: got %0d diffs want 0", diff11); else passed++;
`ifdef TANIMOTO_STIM_THR_LOAD_EN
    total++; if (first_we != 1) $display("FAIL thr_first_we: got %0d want 1", first_we); else passed++;
    total++; if (thr_d.size() != VW + 1) $display("FAIL thr_count: got %0d want %0d", thr_d.size(), VW + 1); else passed++;
    bad = 0;
    for (int c = 0; c < thr_d.size(); c++) if (thr_a[c] != c || thr_d[c] != thr_model(c, TW)) bad++;
    total++; if (bad != 0) $display("FAIL thr_table: got %0d bad entries want 0", bad); else passed++;
    if (thr_d.size() == VW + 1) begin
      total++; if (thr_d[1] != 3) $display("FAIL thr_1: got %0d want 3", thr_d[1]); else passed++;
      total++; if (thr_d[34] != 134) $display("FAIL thr_34: got %0d want 134", thr_d[34]); else passed++;
      total++; if (thr_d[920] != 3625) $display("FAIL thr_920: got %0d want 3625", thr_d[920]); else passed++;
    end
`else
    total++; if (tied_err != 0) $display("FAIL thr_tied_off: got %0d active cycles want 0", tied_err); else passed++;
    total++; if (first_v != 3) $display("FAIL nothr_first_tvalid: got %0d want 3", first_v); else passed++;
`endif
  endtask

  task automatic test_saturation();
`ifdef TANIMOTO_STIM_THR_LOAD_EN
    int bad = 0;
    do_run(0, 100, 0);
    total++; if (thr_d11.size() != VW + 1) $display("FAIL sat_count: got %0d want %0d", thr_d11.size(), VW + 1); else passed++;
    for (int c = 0; c < thr_d11.size(); c++) if (thr_d11[c] != thr_model(c, 11)) bad++;
    total++; if (bad != 0) $display("FAIL sat_table: got %0d bad entries want 0", bad); else passed++;
    if (thr_d11.size() == VW + 1) begin
      total++; if (thr_d11[519] != 2045) $display("FAIL sat_519: got %0d want 2045", thr_d11[519]); else passed++;
      total++; if (thr_d11[520] != 2047) $display("FAIL sat_520: got %0d want 2047", thr_d11[520]); else passed++;
      total++; if (thr_d11[920] != 2047) $display("FAIL sat_920: got %0d want 2047", thr_d11[920]); else passed++;
    end
`endif
  endtask

  task automatic test_backpressure();
    int bad;
    do_run(0, 30, 0);
    total++; if (timed_out != 0) $display("FAIL bp_timeout: got %0d want 0", timed_out); else passed++;
    total++; if (beats.size() != NB) $display("FAIL bp_beats: got %0d want %0d", beats.size(), NB); else passed++;
    bad = beat_errors();
    total++; if (bad != 0) $display("FAIL bp_data: got %0d bad beats want 0", bad); else passed++;
    total++; if (stable_err != 0) $display("FAIL bp_stall_stable: got %0d unstable cycles want 0", stable_err); else passed++;
    total++; if (stray_last != 0) $display("FAIL bp_stray_tlast: got %0d want 0", stray_last); else passed++;
    bad = 0;
    for (int k = 0; k < lasts.size(); k++) if (lasts[k] !== (k == NB-1)) bad++;
    total++; if (bad != 0) $display("FAIL bp_tlast: got %0d bad flags want 0", bad); else passed++;
    total++; if (done_cnt != 1) $display("FAIL bp_done_count: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_gap();
    int bad = 0;
    do_run(3, 100, 0);
    total++; if (timed_out != 0) $display("FAIL gap_timeout: got %0d want 0", timed_out); else passed++;
    total++; if (beats.size() != NB) $display("FAIL gap_beats: got %0d want %0d", beats.size(), NB); else passed++;
    for (int k = 1; k < hs_i.size(); k++) if (hs_i[k] - hs_i[k-1] != 4) bad++;
    total++; if (bad != 0) $display("FAIL gap_spacing: got %0d bad intervals want 0", bad); else passed++;
    total++; if (last_hs() - first_en + 1 != 919) $display("FAIL gap_duration: got %0d want 919", last_hs() - first_en + 1); else passed++;
    bad = beat_errors();
    total++; if (bad != 0) $display("FAIL gap_data: got %0d bad beats want 0", bad); else passed++;
  endtask

  task automatic test_reset_restart();
    int bad;
    do_run(0, 100, 100);
    total++; if (timed_out != 0 || beats.size() != 100) $display("FAIL abort_reach: got %0d beats want 100", beats.size()); else passed++;
    @(negedge clk); rst = 1'b1; start = 1'b1; tready = 1'b1;
    @(negedge clk); #1;
    total++; if (tvalid !== 1'b0) $display("FAIL abort_tvalid: got %b want 0", tvalid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else passed++;
    total++; if (rom_en !== 1'b0) $display("FAIL abort_rom_en: got %b want 0", rom_en); else passed++;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    do_run(0, 100, 0);
    total++; if (timed_out != 0) $display("FAIL restart_timeout: got %0d want 0", timed_out); else passed++;
    total++; if (first_rom_addr != 0) $display("FAIL restart_rom_addr: got %0d want 0", first_rom_addr); else passed++;
    total++; if (beats.size() != NB) $display("FAIL restart_beats: got %0d want %0d", beats.size(), NB); else passed++;
    bad = beat_errors();
    total++; if (bad != 0) $display("FAIL restart_data: got %0d bad beats want 0", bad); else passed++;
    total++; if (done_cnt != 1) $display("FAIL restart_done_count: got %0d want 1", done_cnt); else passed++;
`ifdef TANIMOTO_STIM_THR_LOAD_EN
    total++; if (thr_a.size() == 0 || thr_a[0] != 0) $display("FAIL restart_thr_addr: got %0d entries want first addr 0", thr_a.size()); else passed++;
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tready = 1'b0; gap = 4'd0;
    for (int k = 0; k < NB; k++) image[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_gap();
    test_reset_restart();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
